// File: rtl/mem_access_unit_pkg.sv
// Shared codes for the data-memory access unit: regwrite modes,
// access sizes, FSM states and request size/alignment helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stores take req_size (11 = word);
  // loads derive size from the mode.
  function automatic logic [1:0] acc_size(
    input logic       store,
    input logic [1:0] size,
    input logic [2:0] rw
  );
    logic [1:0] s;
    if (store) begin
      s = (size == 2'b11) ? SZ_W : size;
    end else begin
      unique case (1'b1)
        (rw == LB) || (rw == LBU): s = SZ_B;
        (rw == LH) || (rw == LHU): s = SZ_H;
        default:                   s = SZ_W;
      endcase
    end
    return s;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Lane alignment: byte enables, replicated store data,
// effective offset and right-aligned load data.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic        store,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lanes,
  output logic [1:0]  eff_off,
  output logic [31:0] shifted
);

  always_comb begin
    be      = 4'b1111;
    lanes   = wdata;
    eff_off = 2'b00;
    unique case (1'b1)
      size == SZ_B: begin
        eff_off = off;
        lanes   = {4{wdata[7:0]}};
        be      = 4'b0001 << off;
      end
      size == SZ_H: begin
        eff_off = {off[1], 1'b0};
        lanes   = {2{wdata[15:0]}};
        be      = 4'b0011 << {off[1], 1'b0};
      end
      default: begin
        eff_off = 2'b00;
        lanes   = wdata;
        be      = 4'b1111;
      end
    endcase
    if (!store) be = 4'b1111;
  end

  assign shifted = rdata >> {eff_off, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access FSM (IDLE/BUSY/DONE); stalls the
// pipeline until mem_ack, then pulses wb_valid with aligned data.
// Ports: req_* from MEM, mem_* to memory, wb_* to WB, stall out.
// MISALIGN_CHECK_EN adds wb_misalign and skips misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_regwrite,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [1:0]        wb_bytesel,
  output logic [2:0]        wb_regwrite
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              wb_misalign
`endif
);

  state_t state, nxt;

  logic              c_store;
  logic [1:0]        c_size;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [2:0]        c_rw;

  logic [1:0]  req_sz;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [1:0]  al_off;
  logic [31:0] al_rdata;
  logic        mis;

  assign req_sz = acc_size(req_store, req_size, req_regwrite);

`ifdef MISALIGN_CHECK_EN
  assign mis = misaligned(req_sz, req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .store   (c_store),
    .size    (c_size),
    .off     (c_addr[1:0]),
    .wdata   (c_wdata),
    .rdata   (mem_rdata),
    .be      (al_be),
    .lanes   (al_wdata),
    .eff_off (al_off),
    .shifted (al_rdata)
  );

  always_comb begin
    nxt       = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    wb_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) nxt = mis ? DONE : BUSY;
      end
      BUSY: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = c_store;
        mem_be    = al_be;
        mem_addr  = {c_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = al_wdata;
        if (mem_ack) nxt = DONE;
      end
      DONE: begin
        wb_valid = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      c_store     <= 1'b0;
      c_size      <= SZ_W;
      c_addr      <= '0;
      c_wdata     <= '0;
      c_rw        <= NOREGWRITE;
      wb_data     <= '0;
      wb_bytesel  <= 2'b00;
      wb_regwrite <= NOREGWRITE;
`ifdef MISALIGN_CHECK_EN
      wb_misalign <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        c_store <= req_store;
        c_size  <= req_sz;
        c_addr  <= req_addr;
        c_wdata <= req_wdata;
        c_rw    <= req_regwrite;
      end
`ifdef MISALIGN_CHECK_EN
      if (state == IDLE && req_valid && mis) begin
        wb_data     <= '0;
        wb_bytesel  <= req_addr[1:0];
        wb_regwrite <= NOREGWRITE;
        wb_misalign <= 1'b1;
      end
`endif
      if (state == BUSY && mem_ack) begin
        wb_data     <= al_rdata;
        wb_bytesel  <= al_off;
        wb_regwrite <= c_store ? NOREGWRITE : c_rw;
`ifdef MISALIGN_CHECK_EN
        wb_misalign <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus
// random loads/stores against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_regwrite;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [1:0]  wb_bytesel;
  logic [2:0]  wb_regwrite;
`ifdef MISALIGN_CHECK_EN
  logic        wb_misalign;
`endif

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_regwrite (req_regwrite),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_bytesel   (wb_bytesel),
    .wb_regwrite  (wb_regwrite)
`ifdef MISALIGN_CHECK_EN
    ,
    .wb_misalign  (wb_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  bytesel;
    logic [2:0]  rw;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: sizes in bytes, offsets by plain arithmetic.
  function automatic int nbytes(input logic st, input logic [1:0] sz,
                                input logic [2:0] rw);
    if (st) return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (rw == 3'd1 || rw == 3'd4) return 1;
    if (rw == 3'd2 || rw == 3'd5) return 2;
    return 4;
  endfunction

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 required 0");
      end else begin
        exp_t e;
        e = q.pop_front();
`ifdef MISALIGN_CHECK_EN
        chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
        if (!e.mis) chk("wb_data", wb_data, e.data);
`else
        chk("wb_data", wb_data, e.data);
`endif
        chk("wb_bytesel", 32'(wb_bytesel), 32'(e.bytesel));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
      end
    end
  end

  task automatic txn(input logic st, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] rw, input logic [31:0] rd,
                     input int w, input bit hold);
    int n, off;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eaddr;
    exp_t e;
    bit mis;
    n   = nbytes(st, sz, rw);
    off = (int'(a[1:0]) / n) * n;
    ebe = st ? 4'(((1 << n) - 1) << off) : 4'hf;
    for (int b = 0; b < 4; b++) ewd[8*b +: 8] = wd[8*(b % n) +: 8];
    eaddr = a & 32'hffff_fffc;
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = (int'(a[1:0]) % n) != 0;
`endif
    e.data    = rd >> (8 * off);
    e.bytesel = mis ? a[1:0] : 2'(off);
    e.rw      = (st || mis) ? 3'd0 : rw;
    e.mis     = mis;
    req_valid = 1'b1;
    req_store = st;
    req_size = sz;
    req_addr = a;
    req_wdata = wd;
    req_regwrite = rw;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    q.push_back(e);
    if (!mis) begin
      for (int i = 0; i <= w; i++) begin
        if (i == w) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        chk("busy_mem_req", 32'(mem_req), 32'd1);
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_we", 32'(mem_we), 32'(st));
        chk("busy_be", 32'(mem_be), 32'(ebe));
        chk("busy_addr", mem_addr, eaddr);
        if (st) chk("busy_wdata", mem_wdata, ewd);
        chk("busy_no_wb", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    chk("done_wb_valid", 32'(wb_valid), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int c);
    req_valid = 1'b0;
    for (int i = 0; i < c; i++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      chk("gap_mem_req", 32'(mem_req), 32'd0);
      chk("gap_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size = 2'd0;
    req_addr = '0;
    req_wdata = '0;
    req_regwrite = 3'd0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;

    // LB 0x103, ack in first BUSY cycle
    txn(1'b0, 2'd0, 32'h103, 32'h0, 3'd1, 32'hAABBCCDD, 0, 1'b0);
    // SH 0x22 with three wait cycles
    txn(1'b1, 2'd1, 32'h22, 32'h1234, 3'd0, 32'h0, 3, 1'b0);
    // SW then LHU, req_valid held through DONE
    txn(1'b1, 2'd2, 32'h80, 32'hCAFEF00D, 3'd0, 32'h0, 1, 1'b1);
    txn(1'b0, 2'd0, 32'h40, 32'h0, 3'd5, 32'h0000BEEF, 0, 1'b0);
`ifndef MISALIGN_CHECK_EN
    // LW to 0x101 is truncated to the word at 0x100
    txn(1'b0, 2'd0, 32'h101, 32'h0, 3'd3, 32'h11223344, 1, 1'b0);
`else
    txn(1'b0, 2'd0, 32'h101, 32'h0, 3'd3, 32'h11223344, 1, 1'b0);
    txn(1'b1, 2'd1, 32'h203, 32'h5555, 3'd0, 32'h0, 0, 1'b0);
`endif

    // Reset during BUSY with ack on the same edge
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr = 32'h300;
    req_regwrite = 3'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rstb_mem_req", 32'(mem_req), 32'd0);
    chk("rstb_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstb_stall", 32'(stall), 32'd0);
    chk("rstb_mem_be", 32'(mem_be), 32'd0);
    chk("rstb_mem_addr", mem_addr, 32'd0);
    chk("rstb_mem_wdata", mem_wdata, 32'd0);
    chk("rstb_wb_data", wb_data, 32'd0);
    chk("rstb_wb_bytesel", 32'(wb_bytesel), 32'd0);
    chk("rstb_wb_rw", 32'(wb_regwrite), 32'd0);
    @(posedge clk);
    #1;
    gap(2);

    for (int k = 0; k < 200; k++) begin
      logic        st;
      logic [1:0]  sz;
      logic [2:0]  rw;
      logic [31:0] a;
      bit          hold;
      int          n;
      st = 1'($urandom);
      sz = 2'($urandom);
      rw = st ? 3'($urandom) : 3'($urandom_range(0, 5));
      a  = $urandom;
`ifdef MISALIGN_CHECK_EN
      n = nbytes(st, sz, rw);
      a = a - 32'(int'(a[1:0]) % n);
`else
      n = 0;
`endif
      hold = ($urandom_range(0, 3) == 0) && (n >= 0);
      txn(st, sz, a, $urandom, rw, $urandom,
          $urandom_range(0, 4), hold);
      if (!hold) gap($urandom_range(0, 2));
    end
    gap(2);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
